// File: rtl/data_mem_pkg.sv
// Shared encodings for the data-memory adapter and its load alignment helper.
package data_mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        RESP
    } state_t;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half/word from a RAM word and sign/zero extends it.
module load_align
    import data_mem_pkg::*;
(
    input  logic [31:0] dout,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] rdata
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Lane extraction and extension; the sign bit is the top bit of the field.
    always_comb begin
        lane_b = dout[{offset, 3'b000} +: 8];
        lane_h = dout[{offset[1], 4'b0000} +: 16];
        rdata  = dout;
        case (size)
            SIZE_B:  rdata = {{24{~uns & lane_b[7]}}, lane_b};
            SIZE_H:  rdata = {{16{~uns & lane_h[15]}}, lane_h};
            default: rdata = dout;
        endcase
    end

endmodule

// File: rtl/data_mem_adapter.sv
// Core load/store to byte-enable RAM adapter, one transaction outstanding.
module data_mem_adapter
    import data_mem_pkg::*;
#(
    parameter int SIZE       = 1024,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_di,
    input  logic [31:0]           mem_dout
);

    // One extra bit so the byte-address limit never wraps for any ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(SIZE * 4);

    state_t      state, state_nxt;
    logic        accept;
    logic        err;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] load_data;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready & ~rst;
    assign mem_addr  = {req_addr[ADDR_WIDTH-1:2], 2'b00};

    // Access fault: illegal size, misalignment or beyond the end of the RAM.
    always_comb begin
        err = 1'b0;
        case (req_size)
            SIZE_B:  err = 1'b0;
            SIZE_H:  err = req_addr[0];
            SIZE_W:  err = |req_addr[1:0];
            default: err = 1'b1;
        endcase
        if ({1'b0, req_addr} >= ADDR_LIMIT) begin
            err = 1'b1;
        end
    end

    // Store lane replication and byte enables, only on a fault-free accepted store.
    always_comb begin
        mem_we = '0;
        case (req_size)
            SIZE_B:  mem_di = {4{req_wdata[7:0]}};
            SIZE_H:  mem_di = {2{req_wdata[15:0]}};
            default: mem_di = req_wdata;
        endcase
        if (accept && req_we && !err) begin
            case (req_size)
                SIZE_B:  mem_we = 4'b0001 << req_addr[1:0];
                SIZE_H:  mem_we = 4'b0011 << req_addr[1:0];
                default: mem_we = 4'b1111;
            endcase
        end
    end

    load_align u_load_align (
        .dout   (mem_dout),
        .offset (off_q),
        .size   (size_q),
        .uns    (uns_q),
        .rdata  (load_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: stores and faults answer directly, clean loads wait one RAM cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (req_we || err) ? RESP : READ;
                end
            end
            READ:    state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latching and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            off_q     <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        off_q     <= req_addr[1:0];
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        rsp_err   <= err;
                        rsp_rdata <= '0;
                        rsp_valid <= req_we | err;
                    end
                end
                READ: begin
                    rsp_rdata <= load_data;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: rsp_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_adapter.sv
// Self-checking bench for data_mem_adapter with a byte-level reference model.
module tb_data_mem_adapter;
    import data_mem_pkg::*;

    localparam int SIZE = 1024;
    localparam int AW   = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_di;
    logic [31:0]   mem_dout;

    int checks = 0;
    int fails  = 0;
    logic [31:0] last_rdata;

    logic [31:0] ram     [0:SIZE-1];
    logic [7:0]  ref_mem [0:4*SIZE-1];

    data_mem_adapter #(.SIZE(SIZE), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_di       (mem_di),
        .mem_dout     (mem_dout)
    );

    always #5 clk = ~clk;

    // Byte-write-enable RAM, read-first, registered read.
    always @(posedge clk) begin
        mem_dout <= ram[mem_addr[11:2]];
        for (int k = 0; k < 4; k++) begin
            if (mem_we[k]) ram[mem_addr[11:2]][8*k +: 8] <= mem_di[8*k +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic [31:0] addr, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd, input int hold);
        int n;
        int lat;
        logic e;
        logic [3:0]  xwe;
        logic [31:0] xdi;
        logic [31:0] xrd;
        logic [31:0] held;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e = (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) ||
            (sz == 2'd2 && addr % 4 != 0) || (addr >= 32'(4 * SIZE));
        xwe = '0;
        xdi = '0;
        xrd = '0;
        for (int k = 0; k < 4; k++) xdi[8*k +: 8] = wd[8*(k % n) +: 8];
        if (we && !e) for (int i = 0; i < n; i++) xwe[addr % 4 + i] = 1'b1;
        if (!we && !e) begin
            for (int i = 0; i < n; i++) xrd = xrd + ({24'b0, ref_mem[addr + i]} << (8 * i));
            if (!uns && n < 4 && xrd[8*n-1]) xrd = xrd - (32'd1 << (8 * n));
        end
        if (we && !e) for (int i = 0; i < n; i++) ref_mem[addr + i] = wd[8*i +: 8];

        @(negedge clk);
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_addr = addr; req_we = we; req_size = sz;
        req_unsigned = uns; req_wdata = wd;
        #1;
        chk("mem_we_accept", {28'b0, mem_we}, {28'b0, xwe});
        if (!e) chk("mem_addr", mem_addr, addr & ~32'd3);
        if (we && !e) chk("mem_di", mem_di, xdi);
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_we = 1'($urandom);
        req_size = 2'($urandom); req_unsigned = 1'($urandom); req_wdata = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!rsp_valid) chk("mem_we_wait", {28'b0, mem_we}, 32'd0);
        end while (!rsp_valid && lat < 6);
        chk("latency", 32'(lat), (we || e) ? 32'd1 : 32'd2);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e});
        chk("rsp_rdata", rsp_rdata, xrd);
        last_rdata = rsp_rdata;
        held = rsp_rdata;
        if (hold > 0) begin
            req_valid = 1'b1; req_we = 1'b1; req_size = SIZE_W; req_addr = '0; req_wdata = 32'hCAFE0000;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
                chk("bp_rsp_rdata", rsp_rdata, held);
                chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
                chk("bp_mem_we", {28'b0, mem_we}, 32'd0);
            end
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rsp_valid_drop", {31'b0, rsp_valid}, 32'd0);
        chk("req_ready_back", {31'b0, req_ready}, 32'd1);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra;
        for (int i = 0; i < SIZE; i++) ram[i] = '0;
        for (int i = 0; i < 4 * SIZE; i++) ref_mem[i] = '0;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_size = '0;
        req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", {31'b0, req_ready}, 32'd1);

        // Stores and loads from the directed plan.
        txn(32'h10, 1'b1, SIZE_W, 1'b0, 32'hDEADBEEF, 0);
        txn(32'h13, 1'b1, SIZE_B, 1'b0, 32'h0000005A, 0);
        txn(32'h12, 1'b1, SIZE_H, 1'b0, 32'h00001234, 0);
        txn(32'h10, 1'b1, SIZE_W, 1'b0, 32'h8899AABB, 0);
        txn(32'h11, 1'b0, SIZE_B, 1'b0, 32'h0, 0);
        chk("ld_sb_const", last_rdata, 32'hFFFFFFAA);
        txn(32'h11, 1'b0, SIZE_B, 1'b1, 32'h0, 0);
        chk("ld_ub_const", last_rdata, 32'h000000AA);
        txn(32'h12, 1'b0, SIZE_H, 1'b0, 32'h0, 0);
        chk("ld_sh_const", last_rdata, 32'hFFFF8899);
        txn(32'h10, 1'b0, SIZE_W, 1'b0, 32'h0, 0);
        chk("ld_w_const", last_rdata, 32'h8899AABB);

        // Faults.
        txn(32'h11, 1'b1, SIZE_H, 1'b0, 32'h1111, 0);
        txn(32'h12, 1'b0, SIZE_W, 1'b0, 32'h0, 0);
        txn(32'h14, 1'b0, 2'b11, 1'b0, 32'h0, 0);
        txn(32'h1000, 1'b0, SIZE_W, 1'b0, 32'h0, 0);
        txn(32'hFFC, 1'b1, SIZE_W, 1'b0, 32'h01020304, 0);
        txn(32'hFFF, 1'b0, SIZE_B, 1'b1, 32'h0, 0);

        // Backpressure on a load response.
        txn(32'h10, 1'b0, SIZE_W, 1'b0, 32'h0, 3);

        // Reset during READ drops the load.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h10; req_we = 1'b0; req_size = SIZE_W;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_size = SIZE_W; req_wdata = 32'h55555555;
        #1;
        chk("rst_mem_we", {28'b0, mem_we}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
        end
        rsp_ready = 1'b0;

        // Randomized traffic against the byte model.
        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 9))
                0:       ra = $urandom_range(4088, 4200);
                1:       ra = $urandom;
                default: ra = $urandom_range(0, 63);
            endcase
            txn(ra, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
